sub_seq_unit: RTL and testbench
===============================

// Module: sub_seq_unit
// PURPOSE
//   Multi-cycle subtractor/comparator for the RISC-V execute stage: computes a - b as
//   a + ~b + 1, CHUNK bits per clock, with the borrow chained between slices in a register.
//   Produces diff plus the flags used by SUB/SLT/SLTU/BEQ/BNE/BLT/BGE/BLTU/BGEU.
//   Complements the single-cycle lookahead adder; valid/ready handshake on both sides.
// PARAMETERS
//   WIDTH  32  operand/result width in bits
//   CHUNK  8   slice width processed per cycle; WIDTH % CHUNK != 0 is an elaboration error
//   (derived) NSLICE = WIDTH/CHUNK; slice index counter width = clog2(NSLICE), min 1
// PORTS
//   clk        in   1      clock, rising edge
//   rstn       in   1      asynchronous active-low reset
//   in_valid   in   1      request valid
//   in_ready   out  1      unit can accept a request (state IDLE)
//   a          in   WIDTH  minuend, sampled on accept
//   b          in   WIDTH  subtrahend, sampled on accept
//   is_signed  in   1      1: lt is a signed compare; 0: unsigned; sampled on accept
//   out_valid  out  1      result valid (state DONE)
//   out_ready  in   1      consumer takes result
//   diff       out  WIDTH  a - b mod 2^WIDTH
//   borrow     out  1      1 when a < b unsigned (inverted final carry)
//   ovf        out  1      signed overflow: a[MSB]!=b[MSB] && diff[MSB]!=a[MSB]
//   lt         out  1      is_signed ? (diff[MSB]^ovf) : borrow
//   eq         out  1      diff == 0
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, slice idx=0, carry reg=0, operand regs=0,
//     diff=0, borrow/ovf/lt/eq=0, out_valid=0; in_ready=1 while in IDLE, including in reset.
//     An in-flight operation is discarded; nothing is emitted for it.
//   FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid at a rising edge: latch a, b (as ~b), is_signed; carry=1;
//     idx=0; go RUN. No in_valid: stay.
//   RUN: in_ready=0, out_valid=0. Each edge: {c,s} = a[idx] + ~b[idx] + carry (CHUNK-bit
//     slice); write s into diff slice idx; carry<=c; idx<=idx+1. On the edge processing
//     slice NSLICE-1: compute flags from final carry and the completed diff, go DONE.
//   DONE: out_valid=1, all outputs held stable until out_ready=1 at an edge, then go IDLE.
//     in_valid during RUN/DONE is ignored (not captured, no side effect).
//   Latency: out_valid rises exactly NSLICE edges after the accepting edge (CHUNK==WIDTH
//     gives 1). Throughput: one bubble IDLE cycle between results; max 1 op per NSLICE+2.
//   diff/flags registers are not cleared on out handshake; they are meaningful only while
//     out_valid=1 and are overwritten slice by slice during the next RUN.
//   Flags computed on full WIDTH only; intermediate slice carries never appear on ports.
//   Width rules: slice add CHUNK+1 bits; wrap mod 2^WIDTH; borrow = ~final carry.
// TESTING
//   (all WIDTH=32, CHUNK=8 unless noted)
//   1. a=5,b=3,is_signed=0 -> diff=2,borrow=0,lt=0,eq=0,ovf=0; out_valid 4 edges after accept.
//   2. a=3,b=5 -> diff=0xFFFFFFFE,borrow=1,lt=1 for is_signed=0 and 1; a=0x100,b=1
//      -> diff=0x000000FF (borrow crosses slice boundary).
//   3. a=0x80000000,b=1 -> diff=0x7FFFFFFF,ovf=1; is_signed=1 -> lt=1; is_signed=0 -> lt=0,borrow=0.
//   4. a=b=0x12345678 -> diff=0,eq=1,borrow=0,lt=0; also a=0,b=0xFFFFFFFF signed -> lt=0, diff=1.
//   5. Backpressure: out_ready=0 for 5 cycles in DONE -> outputs bit-stable, in_ready=0, in_valid
//      pulses ignored; out_ready=1 -> IDLE next edge, next request accepted correctly.
//   6. rstn low during RUN at idx=2 -> out_valid=0,diff=0,in_ready=1 immediately; after release
//      a=10,b=4 -> diff=6. Repeat with CHUNK=32: latency 1 edge.

Source files
------------

// File: rtl/sub_seq_unit_if.sv
// Request/result handshake bundle for the sequential subtractor/comparator.
// The master drives requests and consumes results; the slave is the execute unit.
interface sub_seq_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
    logic             lt;
    logic             eq;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, diff, borrow, ovf, lt, eq
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, diff, borrow, ovf, lt, eq
    );
endinterface

// File: rtl/sub_seq_unit.sv
// Multi-cycle a - b (as a + ~b + 1), CHUNK bits per clock with a registered borrow chain.
// Produces diff and the borrow/ovf/lt/eq flags for SUB/SLT(U) and the branch compares.
module sub_seq_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic         clk,
    input  logic         rstn,
    sub_seq_unit_if.slave bus
);
    localparam int unsigned NSLICE  = WIDTH / CHUNK;
    localparam int unsigned IdxW    = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NSLICE - 1);

    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("sub_seq_unit: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] nb_q, nb_d;
    logic             signed_q, signed_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;

    logic [CHUNK-1:0] a_slice, nb_slice;
    logic [CHUNK:0]   slice_sum;

    always_comb begin
        a_slice  = '0;
        nb_slice = '0;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            if (idx_q == IdxW'(i)) begin
                a_slice  = a_q[i*CHUNK +: CHUNK];
                nb_slice = nb_q[i*CHUNK +: CHUNK];
            end
        end
        slice_sum = {1'b0, a_slice} + {1'b0, nb_slice} + {{CHUNK{1'b0}}, carry_q};
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        nb_d     = nb_q;
        signed_d = signed_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        lt_d     = lt_q;
        eq_d     = eq_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d      = bus.a;
                    nb_d     = ~bus.b;
                    signed_d = bus.is_signed;
                    carry_d  = 1'b1;
                    idx_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                for (int unsigned i = 0; i < NSLICE; i++) begin
                    if (idx_q == IdxW'(i)) begin
                        diff_d[i*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
                    end
                end
                carry_d = slice_sum[CHUNK];
                idx_d   = idx_q + IdxW'(1);
                if (idx_q == LastIdx) begin
                    idx_d    = '0;
                    state_d  = StDone;
                    borrow_d = ~slice_sum[CHUNK];
                    // nb holds ~b, so equal MSBs here mean a and b had differing signs.
                    ovf_d    = (a_q[WIDTH-1] == nb_q[WIDTH-1]) &&
                               (diff_d[WIDTH-1] != a_q[WIDTH-1]);
                    lt_d     = signed_q ? (diff_d[WIDTH-1] ^ ovf_d) : borrow_d;
                    eq_d     = (diff_d == '0);
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            nb_q     <= '0;
            signed_q <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            nb_q     <= nb_d;
            signed_q <= signed_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            lt_q     <= lt_d;
            eq_q     <= eq_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign bus.ovf       = ovf_q;
    assign bus.lt        = lt_q;
    assign bus.eq        = eq_q;
endmodule

// File: tb/tb_sub_seq_unit.sv
// Bench for sub_seq_unit: CHUNK=8 and CHUNK=32 instances share stimulus and are checked every
// cycle against a transaction-level reference model, plus directed literal cases.
module tb_sub_seq_unit;
    localparam int unsigned WIDTH = 32;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        is_signed = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    always #5 clk = ~clk;

    sub_seq_unit_if #(.WIDTH(WIDTH)) if8 ();
    sub_seq_unit_if #(.WIDTH(WIDTH)) if32 ();

    assign if8.in_valid   = in_valid;
    assign if8.a          = a;
    assign if8.b          = b;
    assign if8.is_signed  = is_signed;
    assign if8.out_ready  = out_ready;
    assign if32.in_valid  = in_valid;
    assign if32.a         = a;
    assign if32.b         = b;
    assign if32.is_signed = is_signed;
    assign if32.out_ready = out_ready;

    sub_seq_unit #(.WIDTH(WIDTH), .CHUNK(8)) u_dut8 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if8)
    );

    sub_seq_unit #(.WIDTH(WIDTH), .CHUNK(32)) u_dut32 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if32)
    );

    // Index 0: CHUNK=8 instance, index 1: CHUNK=32 instance.
    logic        d_in_ready[2];
    logic        d_out_valid[2];
    logic [31:0] d_diff[2];
    logic [3:0]  d_flags[2];  // {borrow, ovf, lt, eq}

    assign d_in_ready[0]  = if8.in_ready;
    assign d_out_valid[0] = if8.out_valid;
    assign d_diff[0]      = if8.diff;
    assign d_flags[0]     = {if8.borrow, if8.ovf, if8.lt, if8.eq};
    assign d_in_ready[1]  = if32.in_ready;
    assign d_out_valid[1] = if32.out_valid;
    assign d_diff[1]      = if32.diff;
    assign d_flags[1]     = {if32.borrow, if32.ovf, if32.lt, if32.eq};

    int    vectors = 0;
    int    miscompares = 0;
    string nm[2] = '{"c8", "c32"};

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Reference result from plain integer arithmetic: {borrow, ovf, lt, eq, diff}.
    function automatic logic [35:0] ref_calc(input logic [31:0] x, input logic [31:0] y,
                                             input logic s);
        longint      sd;
        logic [31:0] d;
        logic        bo, ov, l, e;
        d  = x - y;
        bo = (x < y);
        sd = longint'($signed(x)) - longint'($signed(y));
        ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        l  = s ? ($signed(x) < $signed(y)) : (x < y);
        e  = (x == y);
        return {bo, ov, l, e, d};
    endfunction

    // Model: 0 idle, 1 busy (counting down latency), 2 result presented.
    int          m_lat[2]   = '{4, 1};
    int          m_state[2] = '{0, 0};
    int          m_cnt[2]   = '{0, 0};
    logic [31:0] m_diff[2]  = '{32'h0, 32'h0};
    logic [3:0]  m_flags[2] = '{4'h0, 4'h0};
    bit          m_fresh[2] = '{1'b1, 1'b1};

    always @(posedge clk or negedge rstn) begin
        for (int k = 0; k < 2; k++) begin
            if (!rstn) begin
                m_state[k] <= 0;
                m_cnt[k]   <= 0;
                m_fresh[k] <= 1'b1;
            end else begin
                case (m_state[k])
                    0: if (in_valid) begin
                        {m_flags[k], m_diff[k]} <= ref_calc(a, b, is_signed);
                        m_state[k] <= 1;
                        m_cnt[k]   <= m_lat[k];
                        m_fresh[k] <= 1'b0;
                    end
                    1: begin
                        m_cnt[k] <= m_cnt[k] - 1;
                        if (m_cnt[k] == 1) m_state[k] <= 2;
                    end
                    default: if (out_ready) m_state[k] <= 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s in_ready", nm[k]), 64'(d_in_ready[k]), 64'(m_state[k] == 0));
            chk($sformatf("%s out_valid", nm[k]), 64'(d_out_valid[k]), 64'(m_state[k] == 2));
            if (m_state[k] == 2) begin
                chk($sformatf("%s diff", nm[k]), 64'(d_diff[k]), 64'(m_diff[k]));
                chk($sformatf("%s flags", nm[k]), 64'(d_flags[k]), 64'(m_flags[k]));
            end else if (m_fresh[k]) begin
                chk($sformatf("%s reset diff", nm[k]), 64'(d_diff[k]), 64'h0);
                chk($sformatf("%s reset flags", nm[k]), 64'(d_flags[k]), 64'h0);
            end
        end
    end

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                          input int hold, input bit lit, input logic [31:0] ediff,
                          input logic [3:0] eflags);
        int          lat0, lat1, guard;
        logic [31:0] snap_diff;
        logic [3:0]  snap_flags;
        lat0  = -1;
        lat1  = -1;
        guard = 0;
        while (!(d_in_ready[0] && d_in_ready[1]) && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("ready before request", 64'(d_in_ready[0] && d_in_ready[1]), 64'h1);
        a         = ta;
        b         = tb_v;
        is_signed = ts;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        for (int n = 1; n <= 10; n++) begin
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if (d_out_valid[0] && lat0 < 0) lat0 = n;
            if (d_out_valid[1] && lat1 < 0) lat1 = n;
            if (lat0 > 0 && lat1 > 0) break;
        end
        in_valid = 1'b0;
        chk("latency c8", 64'(lat0), 64'd4);
        chk("latency c32", 64'(lat1), 64'd1);
        if (lit) begin
            chk("lit diff c8", 64'(d_diff[0]), 64'(ediff));
            chk("lit flags c8", 64'(d_flags[0]), 64'(eflags));
            chk("lit diff c32", 64'(d_diff[1]), 64'(ediff));
            chk("lit flags c32", 64'(d_flags[1]), 64'(eflags));
        end
        snap_diff  = d_diff[0];
        snap_flags = d_flags[0];
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom_range(0, 1));
            a        = $urandom;
            b        = $urandom;
            @(posedge clk);
            #1;
            chk("held diff", 64'(d_diff[0]), 64'(snap_diff));
            chk("held flags", 64'(d_flags[0]), 64'(snap_flags));
            chk("held in_ready", 64'(d_in_ready[0]), 64'h0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("idle after take c8", 64'(d_in_ready[0]), 64'h1);
        chk("idle after take c32", 64'(d_in_ready[1]), 64'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rb;
        int          mode;

        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 64'(d_in_ready[0]), 64'h1);
        chk("reset out_valid", 64'(d_out_valid[0]), 64'h0);
        chk("reset diff", 64'(d_diff[0]), 64'h0);
        chk("model pin ovf", 64'(ref_calc(32'h8000_0000, 32'h1, 1'b1)),
            {28'h0, 4'b0110, 32'h7FFF_FFFF});
        chk("model pin eq", 64'(ref_calc(32'h1234_5678, 32'h1234_5678, 1'b0)),
            {28'h0, 4'b0001, 32'h0});
        @(negedge clk);
        #2;
        rstn = 1'b1;

        run_op(32'd5, 32'd3, 1'b0, 0, 1'b1, 32'd2, 4'b0000);
        run_op(32'd3, 32'd5, 1'b0, 1, 1'b1, 32'hFFFF_FFFE, 4'b1010);
        run_op(32'd3, 32'd5, 1'b1, 0, 1'b1, 32'hFFFF_FFFE, 4'b1010);
        run_op(32'h100, 32'd1, 1'b0, 0, 1'b1, 32'h0000_00FF, 4'b0000);
        run_op(32'h8000_0000, 32'd1, 1'b1, 5, 1'b1, 32'h7FFF_FFFF, 4'b0110);
        run_op(32'h8000_0000, 32'd1, 1'b0, 0, 1'b1, 32'h7FFF_FFFF, 4'b0100);
        run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 2, 1'b1, 32'h0, 4'b0001);
        run_op(32'h0, 32'hFFFF_FFFF, 1'b1, 0, 1'b1, 32'h1, 4'b1000);

        // Reset while the CHUNK=8 instance is mid-operation at slice 2.
        a        = 32'hDEAD_BEEF;
        b        = 32'h0123_4567;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #2;
        rstn = 1'b0;
        #1;
        chk("mid-run reset out_valid", 64'(d_out_valid[0]), 64'h0);
        chk("mid-run reset diff", 64'(d_diff[0]), 64'h0);
        chk("mid-run reset in_ready", 64'(d_in_ready[0]), 64'h1);
        chk("mid-run reset c32 out_valid", 64'(d_out_valid[1]), 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rstn = 1'b1;
        run_op(32'd10, 32'd4, 1'b0, 0, 1'b1, 32'd6, 4'b0000);

        for (int i = 0; i < 150; i++) begin
            mode = int'($urandom_range(0, 4));
            ra   = $urandom;
            rb   = $urandom;
            case (mode)
                1: rb = ra;
                2: begin
                    ra = {ra[31], 31'h0} | 32'($urandom_range(0, 3));
                    rb = {rb[31], 31'h7FFF_FFFF} ^ 32'($urandom_range(0, 3));
                end
                3: rb = ra + 32'($urandom_range(0, 2)) - 32'd1;
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0,
                   32'h0, 4'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
